mul_exec_unit: RTL and testbench

MUL_EXEC_UNIT -- requirements
Module: mul_exec_unit

---
 rtl/mul_exec_unit.sv | 164 ++++++++++++++++
 tb/tb_mul_exec_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_exec_unit
// Description : Iterative radix-2 shift-add multiply execution unit for an
//               out-of-order core. Handles MUL / MULH / MULHSU / MULHU.
//               Accepts one instruction from the issue queue when idle,
//               iterates XLEN cycles on operand magnitudes, fixes the sign,
//               then holds the result on the CDB request until granted.
// Ports       : clk, rst (sync, active-high)
//               issue_valid/op/rs1_data/rs2_data/rd_tag -> instruction in
//               ex_done  -> instruction accepted this cycle (combinational)
//               busy     -> unit is holding an instruction
//               cdb_req/cdb_grant/cdb_tag/cdb_data/cdb_data_valid -> CDB side
// Revision    : 1.0 - initial release
// ============================================================================
module mul_exec_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [1:0]       issue_op,
    input  logic [XLEN-1:0]  issue_rs1_data,
    input  logic [XLEN-1:0]  issue_rs2_data,
    input  logic [TAG_W-1:0] issue_rd_tag,
    output logic             ex_done,
    output logic             busy,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_data,
    output logic             cdb_data_valid
);

    localparam int c_CNT_W = $clog2(XLEN);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [1:0] c_OP_MUL    = 2'b00;
    localparam logic [1:0] c_OP_MULH   = 2'b01;
    localparam logic [1:0] c_OP_MULHSU = 2'b10;

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(XLEN - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]     c_ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0]   c_ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};

    // State registers and their next-state values
    logic [1:0]        r_state_q,  w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [2*XLEN-1:0] r_acc_q,    w_acc_d;
    logic [2*XLEN-1:0] r_mcand_q,  w_mcand_d;   // shifts left each step
    logic [XLEN-1:0]   r_mplier_q, w_mplier_d;  // shifts right each step
    logic              r_neg_q,    w_neg_d;
    logic              r_is_mul_q, w_is_mul_d;
    logic [TAG_W-1:0]  r_tag_q,    w_tag_d;
    logic [XLEN-1:0]   r_result_q, w_result_d;

    // Operand sign handling at acceptance
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [2*XLEN-1:0] w_sum;
    logic [2*XLEN-1:0] w_prod;

    assign ex_done        = issue_valid && (r_state_q == c_ST_IDLE) && !rst;
    assign busy           = (r_state_q != c_ST_IDLE);
    assign cdb_req        = (r_state_q == c_ST_DONE);
    assign cdb_data_valid = cdb_req && cdb_grant;
    assign cdb_tag        = r_tag_q;
    assign cdb_data       = r_result_q;

    always_comb begin
        w_a_neg = ((issue_op == c_OP_MULH) || (issue_op == c_OP_MULHSU))
                  && issue_rs1_data[XLEN-1];
        w_b_neg = (issue_op == c_OP_MULH) && issue_rs2_data[XLEN-1];
        w_mag_a = w_a_neg ? (~issue_rs1_data + c_ONE_X) : issue_rs1_data;
        w_mag_b = w_b_neg ? (~issue_rs2_data + c_ONE_X) : issue_rs2_data;

        // One shift-add step: add the aligned multiplicand when the current
        // multiplier LSB is set.
        w_sum  = r_acc_q + (r_mplier_q[0] ? r_mcand_q : '0);
        w_prod = r_neg_q ? (~w_sum + c_ONE_2X) : w_sum;
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_acc_d    = r_acc_q;
        w_mcand_d  = r_mcand_q;
        w_mplier_d = r_mplier_q;
        w_neg_d    = r_neg_q;
        w_is_mul_d = r_is_mul_q;
        w_tag_d    = r_tag_q;
        w_result_d = r_result_q;

        case (r_state_q)
            c_ST_IDLE: begin
                if (ex_done) begin
                    w_is_mul_d = (issue_op == c_OP_MUL);
                    w_tag_d    = issue_rd_tag;
                    w_mcand_d  = {{XLEN{1'b0}}, w_mag_a};
                    w_mplier_d = w_mag_b;
                    w_neg_d    = w_a_neg ^ w_b_neg;
                    w_acc_d    = '0;
                    w_cnt_d    = '0;
                    w_state_d  = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                w_acc_d    = w_sum;
                w_mcand_d  = {r_mcand_q[2*XLEN-2:0], 1'b0};
                w_mplier_d = {1'b0, r_mplier_q[XLEN-1:1]};
                if (r_cnt_q == c_CNT_LAST) begin
                    // Final step: sign-correct and pick the requested half
                    w_cnt_d    = '0;
                    w_result_d = r_is_mul_q ? w_prod[XLEN-1:0]
                                            : w_prod[2*XLEN-1:XLEN];
                    w_state_d  = c_ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            c_ST_DONE: begin
                if (cdb_grant) begin
                    w_state_d = c_ST_IDLE;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= c_ST_IDLE;
            r_cnt_q    <= '0;
            r_acc_q    <= '0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_neg_q    <= 1'b0;
            r_is_mul_q <= 1'b0;
            r_tag_q    <= '0;
            r_result_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_acc_q    <= w_acc_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_neg_q    <= w_neg_d;
            r_is_mul_q <= w_is_mul_d;
            r_tag_q    <= w_tag_d;
            r_result_q <= w_result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_exec_unit
// Description : Self-checking bench for mul_exec_unit. Directed corner cases
//               plus random operations compared against a plain 64-bit
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_exec_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    logic             clk;
    logic             rst;
    logic             issue_valid;
    logic [1:0]       issue_op;
    logic [XLEN-1:0]  issue_rs1_data;
    logic [XLEN-1:0]  issue_rs2_data;
    logic [TAG_W-1:0] issue_rd_tag;
    logic             ex_done;
    logic             busy;
    logic             cdb_req;
    logic             cdb_grant;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             cdb_data_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    mul_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_op       (issue_op),
        .issue_rs1_data (issue_rs1_data),
        .issue_rs2_data (issue_rs2_data),
        .issue_rd_tag   (issue_rd_tag),
        .ex_done        (ex_done),
        .busy           (busy),
        .cdb_req        (cdb_req),
        .cdb_grant      (cdb_grant),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_data_valid (cdb_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full product from signed/unsigned 64-bit arithmetic
    function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        longint    sa;
        longint    sb;
        logic [63:0] p;
        if (op == 2'b01 || op == 2'b10) sa = $signed(a);
        else                            sa = {32'b0, a};
        if (op == 2'b01)                sb = $signed(b);
        else                            sb = {32'b0, b};
        p = sa * sb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one instruction starting at the next cycle, waits for its CDB
    // request, withholds the grant gdelay cycles, ends at the grant cycle.
    task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                         input int gdelay, input bit hold_valid);
        logic [XLEN-1:0] exp;
        int lat;
        exp = model(op, a, b);
        @(posedge clk); #1;
        issue_valid    = 1'b1;
        issue_op       = op;
        issue_rs1_data = a;
        issue_rs2_data = b;
        issue_rd_tag   = tag;
        cdb_grant      = (gdelay == 0);
        @(negedge clk);
        check("ex_done_accept", ex_done, 1);
        acc_cyc = cyc;
        lat = 0;
        do begin
            @(posedge clk); #1;
            issue_valid    = hold_valid;
            issue_op       = 2'($urandom);
            issue_rs1_data = $urandom;
            issue_rs2_data = $urandom;
            issue_rd_tag   = TAG_W'($urandom);
            lat++;
            @(negedge clk);
            if (hold_valid && ex_done) check("ex_done_backpressure", ex_done, 0);
        end while (!cdb_req && lat < 100);
        check("latency", lat, XLEN + 1);
        check("cdb_tag", cdb_tag, tag);
        check("cdb_data", cdb_data, exp);
        check("cdb_dv_first", cdb_data_valid, (gdelay == 0));
        for (int g = 1; g <= gdelay; g++) begin
            @(posedge clk); #1;
            cdb_grant = (g == gdelay);
            @(negedge clk);
            if (!cdb_req || cdb_tag !== tag || cdb_data !== exp) begin
                check("cdb_hold_req", cdb_req, 1);
                check("cdb_hold_tag", cdb_tag, tag);
                check("cdb_hold_data", cdb_data, exp);
            end
            if (cdb_data_valid !== (g == gdelay))
                check("cdb_dv_pulse", cdb_data_valid, (g == gdelay));
            if (hold_valid && ex_done) check("ex_done_done", ex_done, 0);
        end
        check("cdb_dv_grant", cdb_data_valid, 1);
    endtask

    initial begin
        int t1;
        int t2;
        logic [1:0] rop;
        rst = 1'b1; issue_valid = 1'b1; issue_op = 2'b00;
        issue_rs1_data = 32'd5; issue_rs2_data = 32'd5; issue_rd_tag = 6'd1;
        cdb_grant = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ex_done", ex_done, 0);
        check("rst_busy", busy, 0);
        check("rst_cdb_req", cdb_req, 0);
        check("rst_cdb_dv", cdb_data_valid, 0);
        check("rst_cdb_tag", cdb_tag, 0);
        check("rst_cdb_data", cdb_data, 0);
        @(posedge clk); #1;
        rst = 1'b0; issue_valid = 1'b0; cdb_grant = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Directed corners
        do_op(2'b00, 32'd7, 32'd6, 6'd5, 0, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd9, 0, 1'b0);
        check("mulh_m1", cdb_data, 32'h0000_0000);
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10, 0, 1'b0);
        check("mulhu_max", cdb_data, 32'hFFFF_FFFE);
        do_op(2'b10, 32'hFFFF_FFFF, 32'd2, 6'd11, 1, 1'b0);
        check("mulhsu", cdb_data, 32'hFFFF_FFFF);
        do_op(2'b00, 32'h8000_0000, 32'd2, 6'd12, 0, 1'b0);
        check("mul_ovf", cdb_data, 32'h0000_0000);
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 6'd13, 2, 1'b0);

        // Grant withheld 10 cycles with issue_valid held, then back-to-back
        do_op(2'b01, 32'h1234_5678, 32'h8765_4321, 6'd20, 10, 1'b1);
        t1 = acc_cyc;
        do_op(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 6'd21, 0, 1'b1);
        t2 = acc_cyc;
        check("after_grant_accept", t2 - t1, XLEN + 2 + 10);
        do_op(2'b10, 32'h8000_0001, 32'hFFFF_FFFF, 6'd22, 0, 1'b1);
        check("b2b_spacing", acc_cyc - t2, XLEN + 2);
        @(posedge clk); #1;
        issue_valid = 1'b0; cdb_grant = 1'b0;
        @(negedge clk);
        check("post_b2b_busy", busy, 0);

        // Reset in the middle of BUSY discards the instruction
        @(posedge clk); #1;
        issue_valid = 1'b1; issue_op = 2'b00;
        issue_rs1_data = 32'd100; issue_rs2_data = 32'd100; issue_rd_tag = 6'd30;
        cdb_grant = 1'b1;
        @(negedge clk);
        check("rst_mid_accept", ex_done, 1);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1; issue_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_ex_done", ex_done, 0);
        @(posedge clk); #1;
        rst = 1'b0; issue_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cdb_req || cdb_data_valid) check("rst_mid_no_pub", cdb_req, 0);
        end
        check("rst_mid_idle", busy, 0);
        do_op(2'b00, 32'd3, 32'd3, 6'd31, 0, 1'b0);
        check("after_rst_mul", cdb_data, 32'd9);

        // Random operations against the reference model
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom);
            do_op(rop, $urandom, $urandom, TAG_W'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end
        @(posedge clk); #1;
        issue_valid = 1'b0; cdb_grant = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
